preg_free_list: RTL and testbench
=================================

# preg_free_list

Physical-register free list for the out-of-order core: hands free physical registers to rename, one per cycle, and takes back the old physical registers that the reorder buffer releases at commit (`free_req`/`free_preg`). It sits between the ROB commit port and the rename stage. It keeps per-branch read-pointer checkpoints so that misprediction recovery reclaims every register allocated after the branch in one cycle, while commits continue to return registers during recovery.

## Interface
- `NUM_PREGS`, 64: physical registers. Must be a power of two; it is also the FIFO depth. `PREG_W = $clog2(NUM_PREGS)`.
- `NUM_AREGS`, 32: architectural registers. Pregs `0..NUM_AREGS-1` are architecturally mapped at reset.
- `N_CKPT`, 8: checkpoint slots. `CKPT_W = $clog2(N_CKPT)`.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `flush_i`  in  1  full pipeline flush; returns the block to its reset state.
- `alloc_req_i`  in  1  rename consumes `alloc_preg_o` this cycle.
- `alloc_valid_o`  out  1  a free preg is available and may be taken.
- `alloc_preg_o`  out  PREG_W  show-ahead head preg.
- `free_req_i`  in  1  commit returns a preg; driven from the ROB `free_req_o`.
- `free_preg_i`  in  PREG_W  preg being returned.
- `checkpoint_take_i`  in  1  snapshot the read pointer for a branch.
- `checkpoint_id_i`  in  CKPT_W  snapshot slot.
- `recover_i`  in  1  mispredict recovery.
- `recover_id_i`  in  CKPT_W  slot to restore.
- `free_count_o`  out  PREG_W+1  number of free pregs.
- `err_o`  out  1  sticky error flag. See Configuration.

## Operation
- Storage is a circular array `mem[NUM_PREGS]` with extended pointers `rd_ptr` and `wr_ptr`, each PREG_W+1 bits. `free_count_o = wr_ptr - rd_ptr`, modulo 2^(PREG_W+1).
- **Reset and flush_i** take priority, in that order:
  - For `i < NUM_PREGS-NUM_AREGS`: `mem[i] = NUM_AREGS+i`.
  - `rd_ptr = 0`, `wr_ptr = NUM_PREGS-NUM_AREGS`.
  - All checkpoint slots are cleared to 0.
  - `err_o` is cleared on reset only; flush_i does not clear it.
- **Alloc:**
  - `alloc_valid_o = (free_count_o != 0) && !recover_i && !flush_i`.
  - `alloc_preg_o = mem[rd_ptr[PREG_W-1:0]]`. It is combinational and always driven, even when not valid.
  - Fire = `alloc_req_i && alloc_valid_o`. On fire, `rd_ptr` increments.
  - `alloc_req_i` while not valid is ignored.
- **Free:**
  - Accept = `free_req_i && free_preg_i != 0 && free_count_o != NUM_PREGS`.
  - On accept: `mem[wr_ptr] <= free_preg_i`, `wr_ptr` increments.
  - Frees are accepted during recover_i. They are not accepted during flush_i.
- **Checkpoint:**
  - On `checkpoint_take_i && !recover_i`: `ckpt[checkpoint_id_i] <= ` the next-state `rd_ptr`. This includes an alloc fired in the same cycle, so the branch's own destination survives recovery.
  - A checkpoint requested in a recover_i cycle is dropped.
- **Recover:** `rd_ptr <= ckpt[recover_id_i]`. `wr_ptr` still advances on a same-cycle free, so committed frees are never lost.
- **Wrap-around:** pointers wrap naturally. The MSB distinguishes full (count = NUM_PREGS) from empty (count = 0).

## Timing
- Alloc has zero latency: the head is visible in the same cycle and consumed at the clock edge.
- A freed preg becomes allocatable the cycle after it is accepted. There is no free-to-alloc bypass, so a free into an empty list keeps `alloc_valid_o` low that cycle.
- Alloc and free in the same cycle: count is unchanged.
- Recover: `alloc_valid_o` is forced low during the recover cycle. The restored head is visible the next cycle.
- All outputs settle from registered state only. The exception is `alloc_valid_o`, which also depends combinationally on `recover_i` and `flush_i`.
- Reset output values: `alloc_valid_o` = 0 while `rst_n` is low, then 1; `alloc_preg_o` = NUM_AREGS; `free_count_o` = NUM_PREGS-NUM_AREGS; `err_o` = 0.

## Configuration
- Macro: `FREELIST_CHECK_EN`.
- **When defined,** `err_o` is set and held until reset on any of:
  - `free_req_i` with `free_preg_i == 0`;
  - a free while count == NUM_PREGS (overflow; the free is dropped);
  - `alloc_req_i` while `alloc_valid_o == 0` and not recover/flush;
  - a free of a preg already present in the list (linear scan over the valid window).
- **When defined,** each of these events also prints a `$display` line.
- **When not defined,** `err_o` is tied to 0 and there is no scan logic. Dropping behaviour is identical in both builds.

## Test plan
- **Reset drain:** after reset, assert `alloc_req_i` for 32 cycles. Response: `alloc_preg_o` sequence is 32..63; then `alloc_valid_o` = 0 and `free_count_o` = 0.
- **Free then alloc:** from empty, free preg 40. In the same cycle `alloc_valid_o` = 0; the next cycle `alloc_valid_o` = 1, `alloc_preg_o` = 40, and `free_count_o` = 1.
- **Simultaneous alloc and free:** with count = 10, alloc and free preg 5 in the same cycle. Response: count stays 10, and preg 5 appears at the tail after 10 allocs.
- **Checkpoint and recover:**
  - Allocate 33, take a checkpoint in slot 3 in the same cycle, then allocate 34 and 35.
  - Recover slot 3 in the same cycle as freeing preg 7.
  - Required response: next head = 34; count = 31 - 1 + 1 = 31; preg 7 is at the tail.
- **Wrap-around:** run 200 alloc/free pairs through 64 slots. Response: the FIFO order is preserved and `free_count_o` is never corrupted.
- **Flush mid-operation and error checks:**
  - Flush with count = 5 and ptrs wrapped. Response: count = 32, head = 32.
  - With `FREELIST_CHECK_EN`, freeing preg 0 sets `err_o` = 1, and the flag holds until reset.

Source files
------------

// File: rtl/preg_free_list.sv
// Physical-register free list: circular FIFO of free pregs with per-branch read-pointer checkpoints.
// Optional FREELIST_CHECK_EN adds a sticky err_o for zero/overflow/underflow/duplicate-free events.
module preg_free_list #(
  parameter  int NUM_PREGS = 64,
  parameter  int NUM_AREGS = 32,
  parameter  int N_CKPT    = 8,
  localparam int PREG_W    = $clog2(NUM_PREGS),
  localparam int CKPT_W    = $clog2(N_CKPT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              alloc_req_i,
  output logic              alloc_valid_o,
  output logic [PREG_W-1:0] alloc_preg_o,
  input  logic              free_req_i,
  input  logic [PREG_W-1:0] free_preg_i,
  input  logic              checkpoint_take_i,
  input  logic [CKPT_W-1:0] checkpoint_id_i,
  input  logic              recover_i,
  input  logic [CKPT_W-1:0] recover_id_i,
  output logic [PREG_W:0]   free_count_o,
  output logic              err_o
);

  localparam logic [PREG_W:0] FULL_CNT  = (PREG_W+1)'(NUM_PREGS);
  localparam logic [PREG_W:0] RESET_CNT = (PREG_W+1)'(NUM_PREGS - NUM_AREGS);

  logic [PREG_W-1:0] mem  [NUM_PREGS];
  logic [PREG_W:0]   ckpt [N_CKPT];
  logic [PREG_W:0]   rd_ptr;
  logic [PREG_W:0]   wr_ptr;
  logic [PREG_W:0]   rd_ptr_nxt;
  logic              alloc_fire;
  logic              free_accept;

  assign free_count_o  = wr_ptr - rd_ptr;
  // rst_n gating keeps rename from seeing a valid head while the block is held in reset
  assign alloc_valid_o = rst_n && (free_count_o != '0) && !recover_i && !flush_i;
  assign alloc_preg_o  = mem[rd_ptr[PREG_W-1:0]];
  assign alloc_fire    = alloc_req_i && alloc_valid_o;
  assign free_accept   = free_req_i && (free_preg_i != '0) && (free_count_o != FULL_CNT) && !flush_i;
  assign rd_ptr_nxt    = rd_ptr + {{PREG_W{1'b0}}, alloc_fire};

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        mem[i] <= (i < NUM_PREGS - NUM_AREGS) ? PREG_W'(NUM_AREGS + i) : '0;
      end
      for (int j = 0; j < N_CKPT; j++) begin
        ckpt[j] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= RESET_CNT;
    end else begin
      // recovery rewinds the read side only; committed frees keep landing at the tail
      if (recover_i) begin
        rd_ptr <= ckpt[recover_id_i];
      end else begin
        rd_ptr <= rd_ptr_nxt;
      end
      if (free_accept) begin
        mem[wr_ptr[PREG_W-1:0]] <= free_preg_i;
        wr_ptr                  <= wr_ptr + 1'b1;
      end
      if (checkpoint_take_i && !recover_i) begin
        ckpt[checkpoint_id_i] <= rd_ptr_nxt;
      end
    end
  end

`ifdef FREELIST_CHECK_EN
  logic dup_hit;
  logic ev_zero;
  logic ev_ovf;
  logic ev_underflow;
  logic ev_dup;

  // an entry is live when its distance from the head is below the current count
  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < NUM_PREGS; i++) begin
      if (((PREG_W+1)'(PREG_W'(i) - rd_ptr[PREG_W-1:0]) < free_count_o) && (mem[i] == free_preg_i)) begin
        dup_hit = 1'b1;
      end
    end
  end

  assign ev_zero      = free_req_i && (free_preg_i == '0) && !flush_i;
  assign ev_ovf       = free_req_i && (free_preg_i != '0) && (free_count_o == FULL_CNT) && !flush_i;
  assign ev_underflow = alloc_req_i && !alloc_valid_o && !recover_i && !flush_i;
  assign ev_dup       = free_req_i && (free_preg_i != '0) && dup_hit && !flush_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_o <= 1'b0;
    end else begin
      if (ev_zero || ev_ovf || ev_underflow || ev_dup) begin
        err_o <= 1'b1;
      end
      if (ev_zero)      $display("preg_free_list: free of preg 0 dropped");
      if (ev_ovf)       $display("preg_free_list: overflow, free of preg %0d dropped", free_preg_i);
      if (ev_underflow) $display("preg_free_list: alloc request with no free preg");
      if (ev_dup)       $display("preg_free_list: duplicate free of preg %0d", free_preg_i);
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_preg_free_list.sv
// Directed self-checking bench for preg_free_list: drain, free/alloc, checkpoint/recover, wrap, flush, errors.
module tb_preg_free_list;

`ifdef FREELIST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       flush_i;
  logic       alloc_req_i;
  logic       alloc_valid_o;
  logic [5:0] alloc_preg_o;
  logic       free_req_i;
  logic [5:0] free_preg_i;
  logic       checkpoint_take_i;
  logic [2:0] checkpoint_id_i;
  logic       recover_i;
  logic [2:0] recover_id_i;
  logic [6:0] free_count_o;
  logic       err_o;

  int errors = 0;
  int checks = 0;
  int q[$];
  int got;
  int prev;

  preg_free_list dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush_i          (flush_i),
    .alloc_req_i      (alloc_req_i),
    .alloc_valid_o    (alloc_valid_o),
    .alloc_preg_o     (alloc_preg_o),
    .free_req_i       (free_req_i),
    .free_preg_i      (free_preg_i),
    .checkpoint_take_i(checkpoint_take_i),
    .checkpoint_id_i  (checkpoint_id_i),
    .recover_i        (recover_i),
    .recover_id_i     (recover_id_i),
    .free_count_o     (free_count_o),
    .err_o            (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush_i = 0; alloc_req_i = 0; free_req_i = 0; free_preg_i = 0;
    checkpoint_take_i = 0; checkpoint_id_i = 0; recover_i = 0; recover_id_i = 0;
  endtask

  initial begin
    idle();
    rst_n = 0;
    tick(); tick();
    #1;
    chk("rst_valid", {31'd0, alloc_valid_o}, 0);
    chk("rst_head", {26'd0, alloc_preg_o}, 32);
    chk("rst_count", {25'd0, free_count_o}, 32);
    chk("rst_err", {31'd0, err_o}, 0);
    rst_n = 1;
    #1;
    chk("post_rst_valid", {31'd0, alloc_valid_o}, 1);

    // reset drain: 32..63
    for (int i = 0; i < 32; i++) begin
      alloc_req_i = 1;
      #1;
      chk("drain_head", {26'd0, alloc_preg_o}, 32 + i);
      tick();
    end
    idle();
    #1;
    chk("drain_valid", {31'd0, alloc_valid_o}, 0);
    chk("drain_count", {25'd0, free_count_o}, 0);

    // free into empty: no bypass
    free_req_i = 1; free_preg_i = 40;
    #1;
    chk("free_empty_valid", {31'd0, alloc_valid_o}, 0);
    tick();
    idle();
    #1;
    chk("free_then_valid", {31'd0, alloc_valid_o}, 1);
    chk("free_then_head", {26'd0, alloc_preg_o}, 40);
    chk("free_then_count", {25'd0, free_count_o}, 1);

    // fill to 10: 40..49
    for (int i = 41; i <= 49; i++) begin
      free_req_i = 1; free_preg_i = 6'(i);
      tick();
    end
    idle();
    #1;
    chk("fill_count", {25'd0, free_count_o}, 10);
    alloc_req_i = 1; free_req_i = 1; free_preg_i = 5;
    #1;
    chk("simul_head", {26'd0, alloc_preg_o}, 40);
    tick();
    idle();
    #1;
    chk("simul_count", {25'd0, free_count_o}, 10);
    for (int i = 0; i < 10; i++) begin
      alloc_req_i = 1;
      #1;
      chk("simul_order", {26'd0, alloc_preg_o}, (i < 9) ? 41 + i : 5);
      tick();
    end
    idle();
    #1;
    chk("simul_empty", {25'd0, free_count_o}, 0);

    // flush back to reset state
    flush_i = 1;
    #1;
    chk("flush_valid", {31'd0, alloc_valid_o}, 0);
    tick();
    idle();
    #1;
    chk("flush1_count", {25'd0, free_count_o}, 32);
    chk("flush1_head", {26'd0, alloc_preg_o}, 32);

    // checkpoint / recover
    alloc_req_i = 1;
    tick();
    checkpoint_take_i = 1; checkpoint_id_i = 3;
    #1;
    chk("ck_head33", {26'd0, alloc_preg_o}, 33);
    tick();
    idle();
    alloc_req_i = 1;
    tick(); tick();
    idle();
    #1;
    chk("ck_pre_head", {26'd0, alloc_preg_o}, 36);
    chk("ck_pre_count", {25'd0, free_count_o}, 28);
    recover_i = 1; recover_id_i = 3; free_req_i = 1; free_preg_i = 7;
    alloc_req_i = 1; checkpoint_take_i = 1; checkpoint_id_i = 3;
    #1;
    chk("rec_valid", {31'd0, alloc_valid_o}, 0);
    tick();
    idle();
    #1;
    chk("rec_head", {26'd0, alloc_preg_o}, 34);
    chk("rec_count", {25'd0, free_count_o}, 31);
    for (int i = 0; i < 31; i++) begin
      alloc_req_i = 1;
      #1;
      chk("rec_order", {26'd0, alloc_preg_o}, (i < 30) ? 34 + i : 7);
      tick();
    end
    idle();
    recover_i = 1; recover_id_i = 3;
    tick();
    idle();
    #1;
    chk("rec_drop_ck_head", {26'd0, alloc_preg_o}, 34);
    chk("rec_drop_ck_count", {25'd0, free_count_o}, 31);

    // wrap-around: recirculate the preg allocated one cycle earlier
    flush_i = 1;
    tick();
    idle();
    q.delete();
    for (int i = 32; i < 64; i++) q.push_back(i);
    prev = 0;
    for (int k = 0; k < 200; k++) begin
      alloc_req_i = 1;
      free_req_i = (k > 0);
      free_preg_i = 6'(prev);
      #1;
      chk("wrap_head", {26'd0, alloc_preg_o}, q[0]);
      chk("wrap_count", {25'd0, free_count_o}, (k == 0) ? 32 : 31);
      got = q.pop_front();
      if (k > 0) q.push_back(prev);
      prev = got;
      tick();
    end
    idle();
    free_req_i = 1; free_preg_i = 6'(prev);
    tick();
    idle();
    #1;
    chk("wrap_final_count", {25'd0, free_count_o}, 32);

    // flush with count 5 and wrapped pointers
    alloc_req_i = 1;
    for (int i = 0; i < 27; i++) tick();
    idle();
    #1;
    chk("pre_flush_count", {25'd0, free_count_o}, 5);
    flush_i = 1; alloc_req_i = 1; free_req_i = 1; free_preg_i = 7;
    #1;
    chk("flush2_valid", {31'd0, alloc_valid_o}, 0);
    tick();
    idle();
    #1;
    chk("flush2_count", {25'd0, free_count_o}, 32);
    chk("flush2_head", {26'd0, alloc_preg_o}, 32);
    chk("flush2_err", {31'd0, err_o}, 0);

    // free of preg 0 is dropped; err_o only in the checked build
    free_req_i = 1; free_preg_i = 0;
    tick();
    idle();
    #1;
    chk("zero_free_count", {25'd0, free_count_o}, 32);
    chk("zero_free_err", {31'd0, err_o}, {31'd0, CHK});
    tick();
    chk("err_hold", {31'd0, err_o}, {31'd0, CHK});
    flush_i = 1;
    tick();
    idle();
    #1;
    chk("err_hold_flush", {31'd0, err_o}, {31'd0, CHK});
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    chk("err_clr_rst", {31'd0, err_o}, 0);
    chk("final_count", {25'd0, free_count_o}, 32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
